// File: rtl/onehot_decoder_buf.sv
// onehot_decoder_buf: decodes an encoded index into a one-hot vector through a 2-entry valid/ready buffer,
// and keeps a saturating count of accepted "no line" transactions.
module onehot_decoder_buf #(
  parameter int CODE_W = 2,
  parameter int CNT_W = 8,
  localparam int LINES = 2 ** CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_code_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINES-1:0]  out_onehot,
  output logic [CNT_W-1:0]  none_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [LINES-1:0] head, tail, word;
  logic push, pop;
  assign word = in_code_valid ? {{(LINES-1){1'b0}}, 1'b1} << in_code : '0;
  assign in_ready = !rst && state != FULL;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_onehot = out_valid ? head : '0;
  // head always holds the oldest word; tail is only meaningful in FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head <= '0;
      tail <= '0;
      out_valid <= 1'b0;
      none_cnt <= '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head <= word;
          state <= ONE;
          out_valid <= 1'b1;
        end
        ONE: if (push && pop) head <= word;
        else if (push) begin
          tail <= word;
          state <= FULL;
        end else if (pop) begin
          head <= '0;
          state <= EMPTY;
          out_valid <= 1'b0;
        end
        FULL: if (pop) begin
          head <= tail;
          state <= ONE;
        end
        default: begin
          state <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
      if (push && !in_code_valid && none_cnt != '1) none_cnt <= none_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_onehot_decoder_buf.sv
// tb_onehot_decoder_buf: scoreboard bench for onehot_decoder_buf
module tb_onehot_decoder_buf;
  logic clk = 0, rst = 1, in_valid = 0, in_code_valid = 0, out_ready = 0;
  logic [1:0] in_code = 0;
  logic in_ready, out_valid;
  logic [3:0] out_onehot;
  logic [7:0] none_cnt;
  int checks = 0, failures = 0, cnt = 0;
  logic [3:0] q[$];
  always #5 clk = ~clk;
  onehot_decoder_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_code_valid(in_code_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .none_cnt(none_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic [1:0] code, input logic cv, input logic ordy);
    @(negedge clk);
    in_valid = iv;
    in_code = code;
    in_code_valid = cv;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_onehot", out_onehot, q.size() != 0 ? q[0] : 4'b0);
    chk("none_cnt", none_cnt, cnt);
    if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    if (iv && in_ready) begin
      q.push_back(cv ? 4'b1 << code : 4'b0);
      if (!cv && cnt < 255) cnt++;
    end
    @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    in_valid = 1;
    in_code_valid = 0;
    out_ready = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    q.delete();
    cnt = 0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_onehot", out_onehot, 0);
    chk("rst_none_cnt", none_cnt, 0);
    rst = 0;
    in_valid = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), 1, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 2, 0, 1);
    cyc(0, 0, 0, 1);
    chk("none_one", none_cnt, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 2, 1, 0);
    cyc(1, 3, 1, 0);
    cyc(1, 3, 1, 0);
    cyc(1, 3, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 0);
    cyc(1, 3, 1, 1);
    cyc(0, 0, 0, 0);
    chk("push_pop_head", out_onehot, 4'b1000);
    cyc(0, 0, 0, 1);
    repeat (300) cyc(1, 2'($urandom), 0, 1);
    cyc(0, 0, 0, 1);
    chk("none_sat", none_cnt, 255);
    do_reset();
    repeat (300) cyc(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    do_reset();
    cyc(1, 1, 1, 0);
    cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4 && q.size() != 0; i++) cyc(0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
